// File: rtl/operand_sequencer_if.sv
// Bundle of the instruction, sign-extension, register-file and ALU-operand
// signals shared between the operand sequencer and its surroundings.
interface operand_sequencer_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        flush;
    logic [8:0]  seu_nr;
    logic [15:0] seu_result;
    logic        rf_re;
    logic [2:0]  rf_raddr;
    logic [15:0] rf_rdata;
    logic        op_valid;
    logic        op_ready;
    logic [5:0]  op_code;
    logic [15:0] op_data;
    logic        busy;
    logic [7:0]  imm_count;

    modport slave (
        input  instr_valid, instr, flush, seu_result, rf_rdata, op_ready,
        output instr_ready, seu_nr, rf_re, rf_raddr, op_valid, op_code,
        op_data, busy, imm_count
    );

    modport master (
        output instr_valid, instr, flush, seu_result, rf_rdata, op_ready,
        input  instr_ready, seu_nr, rf_re, rf_raddr, op_valid, op_code,
        op_data, busy, imm_count
    );
endinterface

// File: rtl/operand_sequencer.sv
// Fetches one ALU operand per instruction: a sign-extended immediate or a
// register-file value, then holds it on a valid/ready handshake.
module operand_sequencer (
    input  logic               clk,
    input  logic               rst_n,
    operand_sequencer_if.slave bus
);
    localparam int DATA_W = 16;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_EXT  = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    logic [2:0]        state;
    logic [15:0]       instr_q;
    logic [DATA_W-1:0] op_data_q;
    logic [7:0]        imm_count_q;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Flush overrides every transition, including an accept or a handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            instr_q     <= '0;
            op_data_q   <= '0;
            imm_count_q <= '0;
        end else if (bus.flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        instr_q <= bus.instr;
                        state   <= bus.instr[15] ? S_EXT : S_RD;
                    end
                end
                S_EXT: begin
                    op_data_q <= bus.seu_result;
                    state     <= S_OUT;
                end
                S_RD: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    op_data_q <= bus.rf_rdata;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (bus.op_ready) begin
                        state <= S_IDLE;
                        if (instr_q[15]) begin
                            imm_count_q <= sat_inc(imm_count_q);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.instr_ready = (state == S_IDLE);
    assign bus.busy        = (state != S_IDLE);
    assign bus.op_valid    = (state == S_OUT);
    assign bus.rf_re       = (state == S_RD);
    assign bus.rf_raddr    = instr_q[2:0];
    assign bus.seu_nr      = instr_q[8:0];
    assign bus.op_code     = instr_q[14:9];
    assign bus.op_data     = op_data_q;
    assign bus.imm_count   = imm_count_q;
endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: directed and random instructions checked
// against an operand/counter reference model.
module tb_operand_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    operand_sequencer_if bus ();
    operand_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [15:0] rf [8];
    int pass_cnt = 0;
    int total    = 0;
    int exp_imm  = 0;

    // Environment: combinational sign extender and a one-cycle register file.
    assign bus.seu_result = {{7{bus.seu_nr[8]}}, bus.seu_nr};
    always @(posedge clk) if (bus.rf_re) bus.rf_rdata <= rf[bus.rf_raddr];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] ref_data(input logic [15:0] ins);
        int v;
        if (ins[15]) begin
            v = int'(ins[8:0]);
            if (v > 255) v = v - 512;
            return 16'(v);
        end
        return rf[ins[2:0]];
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_op_valid"},    16'(bus.op_valid), 16'h0);
        check({tag, "_rf_re"},       16'(bus.rf_re), 16'h0);
        check({tag, "_busy"},        16'(bus.busy), 16'h0);
        check({tag, "_seu_nr"},      16'(bus.seu_nr), 16'h0);
        check({tag, "_rf_raddr"},    16'(bus.rf_raddr), 16'h0);
        check({tag, "_instr_ready"}, 16'(bus.instr_ready), 16'h1);
        check({tag, "_imm_count"},   16'(bus.imm_count), 16'h0);
        check({tag, "_op_data"},     bus.op_data, 16'h0);
        check({tag, "_op_code"},     16'(bus.op_code), 16'h0);
    endtask

    task automatic run_instr(input logic [15:0] ins, input int stall);
        logic [15:0] ed;
        ed = ref_data(ins);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        bus.op_ready    = (stall == 0);
        check("ready_idle", 16'(bus.instr_ready), 16'h1);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.instr       = 16'($urandom);
        check("busy",        16'(bus.busy), 16'h1);
        check("ready_busy",  16'(bus.instr_ready), 16'h0);
        check("seu_nr",      16'(bus.seu_nr), 16'(ins[8:0]));
        check("rf_raddr",    16'(bus.rf_raddr), 16'(ins[2:0]));
        check("rf_re",       16'(bus.rf_re), 16'(!ins[15]));
        check("early_valid", 16'(bus.op_valid), 16'h0);
        if (!ins[15]) begin
            @(negedge clk);
            check("wait_valid", 16'(bus.op_valid), 16'h0);
            check("wait_rf_re", 16'(bus.rf_re), 16'h0);
        end
        @(negedge clk);
        check("op_valid", 16'(bus.op_valid), 16'h1);
        check("op_data",  bus.op_data, ed);
        check("op_code",  16'(bus.op_code), 16'(ins[14:9]));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("hold_valid", 16'(bus.op_valid), 16'h1);
            check("hold_data",  bus.op_data, ed);
            check("hold_code",  16'(bus.op_code), 16'(ins[14:9]));
            check("hold_ready", 16'(bus.instr_ready), 16'h0);
        end
        bus.op_ready = 1'b1;
        @(negedge clk);
        bus.op_ready = 1'b0;
        if (ins[15] && exp_imm < 255) exp_imm++;
        check("done_idle", 16'(bus.busy), 16'h0);
        check("imm_count", 16'(bus.imm_count), 16'(exp_imm));
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.flush       = 1'b0;
        bus.op_ready    = 1'b0;
        for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
        rf[3] = 16'h1234;

        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        @(negedge clk);

        run_instr(16'h81FF, 0);
        run_instr(16'h8A80, 0);
        run_instr(16'h0403, 0);
        run_instr(16'h0403, 5);
        run_instr(16'h8123, 5);

        // Flush while waiting for register data: no operand ever appears.
        bus.instr = 16'h0405; bus.instr_valid = 1'b1;
        @(negedge clk); bus.instr_valid = 1'b0;
        @(negedge clk); bus.flush = 1'b1;
        @(negedge clk); bus.flush = 1'b0;
        check("flush_wait_busy",  16'(bus.busy), 16'h0);
        check("flush_wait_valid", 16'(bus.op_valid), 16'h0);
        repeat (3) begin
            @(negedge clk);
            check("flush_wait_quiet", 16'(bus.op_valid), 16'h0);
        end
        check("flush_wait_cnt", 16'(bus.imm_count), 16'(exp_imm));

        // Flush coinciding with the operand handshake: no transfer counted.
        bus.instr = 16'h8042; bus.instr_valid = 1'b1;
        @(negedge clk); bus.instr_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 16'(bus.op_valid), 16'h1);
        bus.op_ready = 1'b1; bus.flush = 1'b1;
        @(negedge clk); bus.op_ready = 1'b0; bus.flush = 1'b0;
        check("flush_out_busy", 16'(bus.busy), 16'h0);
        check("flush_out_cnt",  16'(bus.imm_count), 16'(exp_imm));

        // Flush coinciding with an instruction offer: nothing is accepted.
        bus.instr = 16'h8001; bus.instr_valid = 1'b1; bus.flush = 1'b1;
        @(negedge clk); bus.instr_valid = 1'b0; bus.flush = 1'b0;
        check("flush_acc_busy", 16'(bus.busy), 16'h0);
        @(negedge clk);
        check("flush_acc_idle", 16'(bus.busy), 16'h0);

        // Asynchronous reset in the middle of an immediate fetch.
        bus.instr = 16'h81AB; bus.instr_valid = 1'b1;
        @(negedge clk); bus.instr_valid = 1'b0;
        check("ext_busy", 16'(bus.busy), 16'h1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async");
        exp_imm = 0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        run_instr(16'h8003, 0);

        repeat (40) run_instr(16'($urandom), int'($urandom_range(0, 3)));

        exp_imm = 0;
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        repeat (260) run_instr({1'b1, 15'($urandom)}, 0);
        check("sat_255", 16'(bus.imm_count), 16'd255);
        run_instr(16'hFFFF, 1);
        check("sat_hold", 16'(bus.imm_count), 16'd255);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
